// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the ARM pipeline.
// Holds the PC, fetches words from instruction memory over a req/ack
// handshake and presents them to decode/extend with valid/ready.
// Optional performance counters are built when IFETCH_PERF_CNT_EN is defined.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | one quiet cycle after reset, no request issued
//   FETCH  | request outstanding at pc_next, waiting for imem_ack
//   HOLD   | instr holds an undelivered word, waiting for instr_ready
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [23:0] imm_field,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ADDR_MASK;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_next;
  logic        fetch_done;
  logic        accept;

  assign fetch_done = (state == S_FETCH) && imem_ack;
  assign accept     = instr_valid && instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; req and valid come straight from the state
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nxt = S_FETCH;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Instruction register, PC of held instruction and next fetch address
  always_ff @(posedge clk) begin
    if (reset) begin
      instr   <= 32'h0;
      pc      <= RESET_PC_ALIGNED;
      pc_next <= RESET_PC_ALIGNED;
    end else begin
      if (fetch_done) begin
        instr <= imem_rdata;
        pc    <= pc_next;
      end
      if (accept) begin
        pc_next <= pc_src ? (branch_target & ADDR_MASK) : (pc + 32'd4);
      end
    end
  end

  assign imem_addr = pc_next;
  assign imm_field = instr[23:0];
  assign pc_plus8  = pc + 32'd8;

`ifdef IFETCH_PERF_CNT_EN
  // Transfer and stall counters; both wrap naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (accept) fetch_count <= fetch_count + 32'd1;
      if (((state == S_FETCH) && !imem_ack) || ((state == S_HOLD) && !instr_ready))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the ARM processor; sits directly upstream of decode and the `extend` block.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Captures the returned word into an instruction register and presents it downstream with valid/ready.
- Drives `imm_field` (`Instr[23:0]`), which feeds the `extend` data input, and `pc_plus8` for ARM PC-relative operands.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  instruction memory request
- imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0
- imem_ack  in  1  memory response strobe; `imem_rdata` valid in same cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  `instr` holds an undelivered instruction
- instr_ready  in  1  downstream (decode/extend) accepts instruction
- pc_src  in  1  on accept, redirect next fetch to `branch_target`
- branch_target  in  32  redirect address; bits [1:0] ignored (forced 0)
- instr  out  32  instruction register
- imm_field  out  24  `instr[23:0]`, to `extend` data input
- pc  out  32  address of the instruction in `instr`
- pc_plus8  out  32  `pc + 8`, modulo 2^32

Behaviour:
- Reset values (any cycle `reset` is sampled 1, including mid-fetch or mid-hold):
  - state IDLE; `pc_next` = RESET_PC.
  - `instr` = 0, `pc` = RESET_PC, `instr_valid` = 0, `imem_req` = 0.
  - Any outstanding memory transaction is abandoned; an `imem_ack` in the reset cycle is ignored.
- State machine; `imem_req` and `instr_valid` decode directly from state:
  - IDLE: `imem_req` = 0. Always moves to FETCH next cycle.
  - FETCH: `imem_req` = 1; `imem_addr` = `pc_next`, held stable until ack.
    - On `imem_ack` = 1: `instr` <= `imem_rdata`, `pc` <= `pc_next`, go to HOLD.
    - Otherwise stay in FETCH; no timeout.
  - HOLD: `instr_valid` = 1; `instr`, `pc`, `pc_plus8` held stable.
    - On `instr_valid` && `instr_ready`: `pc_next` <= `pc_src` ? {`branch_target`[31:2], 2'b00} : `pc` + 4, then go to FETCH.
    - Otherwise stay in HOLD.
- Latency and throughput:
  - Ack in cycle N -> `instr_valid` = 1 in cycle N+1.
  - Zero-wait-state memory with `instr_ready` tied high gives 1 instruction per 2 cycles.
- Outside the accept cycle: `pc_src` and `branch_target` are ignored in all states.
- `imem_ack` in IDLE or HOLD is ignored.
- Arithmetic: `pc` + 4 and `pc` + 8 are 32-bit and wrap. From 32'hFFFF_FFFC the next fetch is 32'h0000_0000, and `pc_plus8` = 32'h0000_0004.
- `imm_field` is combinational from `instr` and changes only when `instr` does.

Optional Feature:
- Macro: `IFETCH_PERF_CNT_EN`.
- When defined, adds two outputs:
  - `fetch_count` (out, 32): increments by 1 on each valid && ready transfer, wraps, reset to 0.
  - `stall_count` (out, 32): increments by 1 each cycle in FETCH without ack, plus each cycle in HOLD without ready; wraps, reset to 0.
- When not defined, neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Reset and first fetch: RESET_PC = 0, hold `reset` 2 cycles, then release; ack 1 cycle after req with rdata 32'hE3A0_1005.
  -> First post-reset cycle `imem_req` = 0, then `imem_req` = 1 with `imem_addr` = 0.
  -> After ack: `instr_valid` = 1, `instr` = 32'hE3A0_1005, `imm_field` = 24'hA0_1005, `pc` = 0, `pc_plus8` = 8.
- Sequential fetch: keep `instr_ready` = 1, `pc_src` = 0.
  -> Successive `imem_addr` = 0x0, 0x4, 0x8, 0xC; one transfer every 2 cycles with zero-wait ack.
- Downstream stall: hold `instr_ready` = 0 for 5 cycles in HOLD.
  -> `instr`, `pc`, `instr_valid` unchanged; `imem_req` stays 0.
  -> Raising ready produces exactly one transfer.
- Branch redirect: accept with `pc_src` = 1, `branch_target` = 32'h0000_0103.
  -> Next `imem_addr` = 32'h0000_0100.
  -> `pc_src` = 1 asserted while `instr_ready` = 0 has no effect.
- Memory wait and mid-fetch reset: delay ack 4 cycles.
  -> `imem_addr` stable throughout.
  -> Asserting `reset` in wait cycle 2 gives IDLE, `instr_valid` = 0, `pc` = RESET_PC; a later stray ack is ignored.
- Wrap-around: branch to 32'hFFFF_FFFC and accept.
  -> `pc_plus8` = 32'h0000_0004.
  -> Next sequential `imem_addr` = 32'h0000_0000.
